usb_rx_decoder: RTL and testbench
=================================

Name: usb_rx_decoder

Overview:
Front end of the USB full-speed receive path. It takes synchronized D+/D- line samples and recovers bit timing from edges. It NRZI-decodes the stream, removes stuffed bits and detects EOP. It drives the serial bit and shift strobe into the receive shift register, plus byte-boundary, end-of-packet and error strobes for the receive controller.

Parameters:
CLKS_PER_BIT, 8, system clocks per USB bit time (96 MHz / 12 Mbps); must be ≥4.
SAMPLE_PT, 3, bit-timer value at which the line is sampled; must be < CLKS_PER_BIT.
STUFF_LEN, 6, consecutive decoded 1s after which a stuffed 0 is expected.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, synchronous, active-high.
d_plus_sync  in  1  D+ already metastability-synchronized.
d_minus_sync  in  1  D- already metastability-synchronized.
d_orig  out  1  decoded, unstuffed data bit; valid while shift_enable=1.
shift_enable  out  1  one-cycle strobe: accept d_orig.
byte_done  out  1  one-cycle strobe the cycle after the 8th accepted bit of a byte.
eop  out  1  one-cycle strobe on valid end of packet.
rcving  out  1  high from start-of-packet edge until eop or error recovery.
stuff_err  out  1  sticky bit-stuff violation; cleared at next packet start.
sync_err  out  1  sticky SYNC mismatch; see optional feature.

Behaviour:
- Reset: all outputs 0; state IDLE; bit timer 0; NRZI previous level = J (1); ones count 0; bit count 0.
- Line levels: J = (D+=1, D-=0); K = (D+=0, D-=1); SE0 = both 0; SE1 is treated as SE0.
- Edge detect: the edge flag is the registered d_plus_sync XOR current d_plus_sync.
- Bit timer: counts 0..CLKS_PER_BIT-1 and wraps. On an edge in RECEIVE or ERROR it loads 0 that cycle.
- Sample tick: the cycle in which timer == SAMPLE_PT.
- IDLE: on the first edge with D+ going low (J→K):
  - enter RECEIVE, timer to 0, rcving=1;
  - clear stuff_err and sync_err; reset ones count and bit count.
- RECEIVE, at each sample tick:
  - SE0: increment the se0 count; no bit produced.
  - Otherwise:
    - raw = D+;
    - decoded = 1 if raw == previous level, else 0;
    - previous level = raw.
  - If ones count == STUFF_LEN:
    - decoded 0: stuffed bit. Drop it and clear ones count.
    - decoded 1: set stuff_err, go to ERROR.
  - Else: d_orig = decoded and shift_enable=1 the following cycle (latency 1 from the sample tick).
    - Ones count increments on a 1 and clears on a 0.
    - Bit count increments mod 8.
- byte_done: pulses the cycle after the shift_enable that wraps bit count 7→0, so rx_data is already updated.
- EOP_WAIT: entered when the se0 count reaches 2.
  - Next sample J: eop=1 for one cycle, rcving=0, go to IDLE.
  - Next sample K: set stuff_err, go to ERROR.
  - One SE0 followed by J is also an error.
- Partial byte at EOP (bit count ≠ 0): no byte_done; eop is still asserted. Downstream discards the packet.
- ERROR: no shift_enable; wait for the SE0→J sequence, then go to IDLE with eop=0 and rcving=0. The sticky error bit remains set.
- Simultaneous edge and sample tick: the timer reload takes priority and no sample is taken that cycle.
- rst asserted mid-packet: immediate return to reset values on the next edge of clk.

Optional Feature:
USB_RX_SYNC_CHECK_EN
- Defined: the first assembled byte of each packet (decoded LSB-first) is compared against 8'h80, i.e. KJKJKJKK.
  - Mismatch sets sync_err at that byte_done. Reception continues.
- Undefined: sync_err tied to 0 and no compare logic is built.

Decomposition:
- Shared package usb_rx_pkg holds:
  - state enum {IDLE, RECEIVE, EOP_WAIT, ERROR};
  - line-level constants J, K, SE0;
  - SYNC_BYTE = 8'h80.
- One natural sub-module, usb_rx_bit_timer: the timer with edge reload and the sample-tick output.
- NRZI decode, unstuffing and the FSM stay in the top module.

Test Plan:
- SYNC then byte 8'hA5 then SE0,SE0,J at exact bit timing:
  - 16 shift_enable pulses, d_orig sequence matches LSB-first;
  - byte_done twice;
  - eop once; rcving low after eop.
- Data containing six consecutive 1s followed by the stuffed 0 → 6 ones shifted, stuffed bit not shifted, no stuff_err.
- Seven consecutive 1s (missing stuffed 0) → stuff_err=1, no further shift_enable, return to IDLE after SE0,SE0,J with eop=0.
- Line edges drifting ±1 clk every bit over 64 bits → every sample lands 2–4 clks after its edge; no bit lost or duplicated.
- rst pulsed mid-byte after 5 bits → all outputs 0 next cycle. A fresh SYNC then decodes correctly with bit count starting at 0.
- With USB_RX_SYNC_CHECK_EN: first byte 8'h81 → sync_err=1 at first byte_done; with 8'h80 → sync_err stays 0.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// rtl/usb_rx_pkg.sv - shared types and line constants for the USB full-speed receive front end
package usb_rx_pkg;

  typedef enum logic [1:0] {IDLE, RECEIVE, EOP_WAIT, ERROR} rx_state_t;

  // Line levels encoded as {D+, D-}
  localparam logic [1:0] J   = 2'b10;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

  // SE1 is folded into SE0 so only three levels ever reach the decoder
  function automatic logic [1:0] line_level(input logic dp, input logic dm);
    return (dp ^ dm) ? {dp, dm} : SE0;
  endfunction

endpackage

// File: rtl/usb_rx_decoder_if.sv
// rtl/usb_rx_decoder_if.sv - line inputs and decoded-bit strobes between the line side and the receive controller
interface usb_rx_decoder_if;

  logic d_plus_sync;
  logic d_minus_sync;
  logic d_orig;
  logic shift_enable;
  logic byte_done;
  logic eop;
  logic rcving;
  logic stuff_err;
  logic sync_err;

  modport master (
    output d_plus_sync, d_minus_sync,
    input  d_orig, shift_enable, byte_done, eop, rcving, stuff_err, sync_err
  );

  modport slave (
    input  d_plus_sync, d_minus_sync,
    output d_orig, shift_enable, byte_done, eop, rcving, stuff_err, sync_err
  );

endinterface

// File: rtl/usb_rx_bit_timer.sv
// rtl/usb_rx_bit_timer.sv - free-running bit timer with edge realignment and sample-tick output
module usb_rx_bit_timer #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_PT    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic reload,
  output logic sample_tick
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] SPT  = TW'(SAMPLE_PT);

  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_eff;

  // The edge cycle itself counts as timer 0, so the sample lands SAMPLE_PT clocks after the edge
  assign timer_eff   = reload ? '0 : timer_q;
  assign sample_tick = !reload && (timer_q == SPT);

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
    end else begin
      timer_q <= (timer_eff == LAST) ? '0 : timer_eff + 1'b1;
    end
  end

endmodule

// File: rtl/usb_rx_decoder.sv
// rtl/usb_rx_decoder.sv - NRZI decode, bit unstuffing, EOP detection and receive FSM
// Optional SYNC byte check is built when USB_RX_SYNC_CHECK_EN is defined.
module usb_rx_decoder #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_PT    = 3,
  parameter int STUFF_LEN    = 6
) (
  input logic             clk,
  input logic             rst,
  usb_rx_decoder_if.slave bus
);
  import usb_rx_pkg::*;

  localparam int OW = $clog2(STUFF_LEN + 1);
  localparam logic [OW-1:0] ONES_MAX = OW'(STUFF_LEN);

  rx_state_t     state;
  logic          dp_q;
  logic          prev_lvl;
  logic          last_bit_q;
  logic [OW-1:0] ones_cnt;
  logic [2:0]    bit_cnt;
  logic [1:0]    se0_cnt;

  logic [1:0] line;
  logic       edge_det;
  logic       sop;
  logic       reload;
  logic       sample_tick;
  logic       decoded;
  logic       take_bit;
  logic       shift_now;

  assign line      = line_level(bus.d_plus_sync, bus.d_minus_sync);
  assign edge_det  = dp_q ^ bus.d_plus_sync;
  assign sop       = (state == IDLE) && edge_det && (line == K);
  assign reload    = edge_det && (state == RECEIVE || state == ERROR || sop);
  assign decoded   = (bus.d_plus_sync == prev_lvl);
  // A data-carrying sample; after STUFF_LEN ones it must be the stuffed zero instead
  assign take_bit  = (state == RECEIVE) && sample_tick && (line != SE0) && (se0_cnt == 2'd0);
  assign shift_now = take_bit && (ones_cnt != ONES_MAX);

  usb_rx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .SAMPLE_PT   (SAMPLE_PT)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .reload     (reload),
    .sample_tick(sample_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      dp_q             <= 1'b1;
      prev_lvl         <= 1'b1;
      last_bit_q       <= 1'b0;
      ones_cnt         <= '0;
      bit_cnt          <= '0;
      se0_cnt          <= '0;
      bus.d_orig       <= 1'b0;
      bus.shift_enable <= 1'b0;
      bus.byte_done    <= 1'b0;
      bus.eop          <= 1'b0;
      bus.rcving       <= 1'b0;
      bus.stuff_err    <= 1'b0;
    end else begin
      dp_q             <= bus.d_plus_sync;
      bus.shift_enable <= 1'b0;
      bus.eop          <= 1'b0;
      bus.byte_done    <= bus.shift_enable && last_bit_q;
      case (state)
        IDLE: begin
          if (sop) begin
            state         <= RECEIVE;
            bus.rcving    <= 1'b1;
            bus.stuff_err <= 1'b0;
            prev_lvl      <= 1'b1;
            ones_cnt      <= '0;
            bit_cnt       <= '0;
            se0_cnt       <= '0;
          end
        end
        RECEIVE: begin
          if (sample_tick) begin
            if (line == SE0) begin
              se0_cnt <= se0_cnt + 2'd1;
              if (se0_cnt == 2'd1) state <= EOP_WAIT;
            end else if (se0_cnt != 2'd0) begin
              bus.stuff_err <= 1'b1;
              se0_cnt       <= '0;
              state         <= ERROR;
            end else begin
              prev_lvl <= bus.d_plus_sync;
              if (shift_now) begin
                bus.d_orig       <= decoded;
                bus.shift_enable <= 1'b1;
                ones_cnt         <= decoded ? ones_cnt + 1'b1 : '0;
                bit_cnt          <= bit_cnt + 3'd1;
                last_bit_q       <= (bit_cnt == 3'd7);
              end else if (decoded) begin
                bus.stuff_err <= 1'b1;
                state         <= ERROR;
              end else begin
                ones_cnt <= '0;
              end
            end
          end
        end
        EOP_WAIT: begin
          if (sample_tick) begin
            if (line == J) begin
              bus.eop    <= 1'b1;
              bus.rcving <= 1'b0;
              state      <= IDLE;
            end else if (line == K) begin
              bus.stuff_err <= 1'b1;
              se0_cnt       <= '0;
              state         <= ERROR;
            end
          end
        end
        ERROR: begin
          // se0_cnt only remembers that an SE0 was seen; J after it ends recovery
          if (sample_tick) begin
            if (line == SE0) begin
              se0_cnt <= 2'd1;
            end else if (line == J && se0_cnt != 2'd0) begin
              bus.rcving <= 1'b0;
              se0_cnt    <= '0;
              state      <= IDLE;
            end else begin
              se0_cnt <= '0;
            end
          end
        end
      endcase
    end
  end

`ifdef USB_RX_SYNC_CHECK_EN
  logic [7:0] sync_sh;
  logic       first_byte;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_sh      <= '0;
      first_byte   <= 1'b0;
      bus.sync_err <= 1'b0;
    end else if (sop) begin
      first_byte   <= 1'b1;
      bus.sync_err <= 1'b0;
    end else begin
      if (shift_now) sync_sh <= {decoded, sync_sh[7:1]};
      if (bus.shift_enable && last_bit_q && first_byte) begin
        first_byte <= 1'b0;
        if (sync_sh != SYNC_BYTE) bus.sync_err <= 1'b1;
      end
    end
  end
`else
  assign bus.sync_err = 1'b0;
`endif

endmodule

// File: tb/tb_usb_rx_decoder.sv
// tb/tb_usb_rx_decoder.sv - randomized packet bench for usb_rx_decoder against a bit-level line model
module tb_usb_rx_decoder;

  localparam logic [1:0] LJ = 2'b10, LK = 2'b01, LSE0 = 2'b00;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  usb_rx_decoder_if bus();

  usb_rx_decoder #(.CLKS_PER_BIT(8), .SAMPLE_PT(3), .STUFF_LEN(6)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  bit         data_q[$];
  bit         wire_q[$];
  bit         exp_q[$];
  bit         got_q[$];
  logic [1:0] sym_q[$];
  int         dur_q[$];
  int         n_bd, n_eop;
  bit         rcv_seen, bd_seen;
  logic       bd_sync;

  function automatic logic [6:0] outs();
    return {bus.d_orig, bus.shift_enable, bus.byte_done, bus.eop, bus.rcving, bus.stuff_err, bus.sync_err};
  endfunction

  function automatic int bit_errs();
    int e = 0;
    if (got_q.size() != exp_q.size()) return -1;
    foreach (got_q[i]) if (got_q[i] != exp_q[i]) e++;
    return e;
  endfunction

  task automatic cyc();
    @(negedge clk);
    if (!rst) begin
      if (bus.shift_enable) got_q.push_back(bus.d_orig);
      if (bus.byte_done) begin
        n_bd++;
        if (!bd_seen) begin
          bd_seen = 1'b1;
          bd_sync = bus.sync_err;
        end
      end
      if (bus.eop) n_eop++;
      if (bus.rcving) rcv_seen = 1'b1;
    end
  endtask

  task automatic clear_mon();
    got_q.delete();
    n_bd = 0; n_eop = 0; rcv_seen = 1'b0; bd_seen = 1'b0; bd_sync = 1'b0;
  endtask

  task automatic add_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) data_q.push_back(b[i]);
  endtask

  task automatic make_wire(input bit do_stuff);
    int ones = 0;
    wire_q.delete();
    foreach (data_q[i]) begin
      wire_q.push_back(data_q[i]);
      ones = data_q[i] ? ones + 1 : 0;
      if (do_stuff && ones == 6) begin
        wire_q.push_back(1'b0);
        ones = 0;
      end
    end
  endtask

  // NRZI: a 0 toggles the level, a 1 keeps it; boundaries jitter by -1..+1 clk around 8*k
  task automatic make_line(input bit jitter, input bit with_eop);
    logic lvl = 1'b1;
    int   off[$];
    int   n;
    sym_q.delete();
    dur_q.delete();
    foreach (wire_q[i]) begin
      if (!wire_q[i]) lvl = ~lvl;
      sym_q.push_back(lvl ? LJ : LK);
    end
    if (with_eop) begin
      sym_q.push_back(LSE0); sym_q.push_back(LSE0); sym_q.push_back(LJ);
    end
    n = sym_q.size();
    off.push_back(0);
    for (int k = 1; k < n; k++) off.push_back(jitter ? int'($urandom_range(2)) - 1 : 0);
    off.push_back(0);
    for (int k = 0; k < n; k++) dur_q.push_back(8 + off[k+1] - off[k]);
  endtask

  task automatic play();
    foreach (sym_q[i]) begin
      {bus.d_plus_sync, bus.d_minus_sync} = sym_q[i];
      repeat (dur_q[i]) cyc();
    end
  endtask

  task automatic idle(input int n);
    {bus.d_plus_sync, bus.d_minus_sync} = LJ;
    repeat (n) cyc();
  endtask

  task automatic run_packet(input bit do_stuff, input bit jitter);
    make_wire(do_stuff);
    make_line(jitter, 1'b1);
    clear_mon();
    play();
    idle(8);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    {bus.d_plus_sync, bus.d_minus_sync} = LJ;
    repeat (3) @(negedge clk);
    n_checks++;
    if (outs() !== 7'b0) begin n_fail++; $display("FAIL reset_outputs got=%b exp=%b", outs(), 7'b0); end
    rst = 1'b0;
    idle(6);
    n_checks++;
    if (outs() !== 7'b0) begin n_fail++; $display("FAIL idle_outputs got=%b exp=%b", outs(), 7'b0); end
  endtask

  task automatic test_basic();
    data_q.delete(); add_byte(8'h80); add_byte(8'hA5);
    exp_q = data_q;
    run_packet(1'b1, 1'b0);
    n_checks++;
    if (bit_errs() != 0) begin n_fail++; $display("FAIL basic_bits got_len=%0d exp_len=%0d errs=%0d", got_q.size(), exp_q.size(), bit_errs()); end
    n_checks++;
    if (n_bd != 2) begin n_fail++; $display("FAIL basic_byte_done got=%0d exp=2", n_bd); end
    n_checks++;
    if (n_eop != 1) begin n_fail++; $display("FAIL basic_eop got=%0d exp=1", n_eop); end
    n_checks++;
    if (bus.rcving !== 1'b0 || rcv_seen !== 1'b1) begin n_fail++; $display("FAIL basic_rcving got_end=%b seen=%b exp_end=0 seen=1", bus.rcving, rcv_seen); end
  endtask

  task automatic test_stuffing();
    data_q.delete(); add_byte(8'h80); add_byte(8'hFC); add_byte(8'h00);
    exp_q = data_q;
    run_packet(1'b1, 1'b0);
    n_checks++;
    if (bit_errs() != 0) begin n_fail++; $display("FAIL stuff_bits got_len=%0d exp_len=%0d errs=%0d", got_q.size(), exp_q.size(), bit_errs()); end
    n_checks++;
    if (n_bd != 3) begin n_fail++; $display("FAIL stuff_byte_done got=%0d exp=3", n_bd); end
    n_checks++;
    if (bus.stuff_err !== 1'b0) begin n_fail++; $display("FAIL stuff_no_err got=%b exp=0", bus.stuff_err); end
    n_checks++;
    if (n_eop != 1) begin n_fail++; $display("FAIL stuff_eop got=%0d exp=1", n_eop); end
  endtask

  task automatic test_stuff_error();
    int run = 0;
    data_q.delete(); add_byte(8'h80); add_byte(8'hFE); add_byte(8'($urandom));
    exp_q.delete();
    for (int i = 0; i < data_q.size(); i++) begin
      run = data_q[i] ? run + 1 : 0;
      if (run == 7) break;
      exp_q.push_back(data_q[i]);
    end
    run_packet(1'b0, 1'b0);
    n_checks++;
    if (bit_errs() != 0) begin n_fail++; $display("FAIL stufferr_bits got_len=%0d exp_len=%0d errs=%0d", got_q.size(), exp_q.size(), bit_errs()); end
    n_checks++;
    if (bus.stuff_err !== 1'b1) begin n_fail++; $display("FAIL stufferr_flag got=%b exp=1", bus.stuff_err); end
    n_checks++;
    if (n_eop != 0) begin n_fail++; $display("FAIL stufferr_eop got=%0d exp=0", n_eop); end
    n_checks++;
    if (bus.rcving !== 1'b0) begin n_fail++; $display("FAIL stufferr_rcving got=%b exp=0", bus.rcving); end
  endtask

  task automatic test_drift();
    data_q.delete(); add_byte(8'h80);
    for (int i = 0; i < 8; i++) add_byte(8'($urandom));
    exp_q = data_q;
    run_packet(1'b1, 1'b1);
    n_checks++;
    if (bit_errs() != 0) begin n_fail++; $display("FAIL drift_bits got_len=%0d exp_len=%0d errs=%0d", got_q.size(), exp_q.size(), bit_errs()); end
    n_checks++;
    if (n_bd != 9) begin n_fail++; $display("FAIL drift_byte_done got=%0d exp=9", n_bd); end
    n_checks++;
    if (n_eop != 1 || bus.stuff_err !== 1'b0) begin n_fail++; $display("FAIL drift_eop got_eop=%0d err=%b exp_eop=1 err=0", n_eop, bus.stuff_err); end
  endtask

  task automatic test_partial_random();
    for (int it = 0; it < 3; it++) begin
      int nbytes = 1 + int'($urandom_range(2));
      int extra  = 1 + int'($urandom_range(6));
      data_q.delete(); add_byte(8'h80);
      for (int i = 0; i < nbytes; i++) add_byte(8'($urandom));
      for (int i = 0; i < extra; i++) data_q.push_back(1'($urandom));
      exp_q = data_q;
      run_packet(1'b1, 1'($urandom));
      n_checks++;
      if (bit_errs() != 0) begin n_fail++; $display("FAIL partial_bits it=%0d got_len=%0d exp_len=%0d errs=%0d", it, got_q.size(), exp_q.size(), bit_errs()); end
      n_checks++;
      if (n_bd != data_q.size() / 8) begin n_fail++; $display("FAIL partial_byte_done it=%0d got=%0d exp=%0d", it, n_bd, data_q.size() / 8); end
      n_checks++;
      if (n_eop != 1) begin n_fail++; $display("FAIL partial_eop it=%0d got=%0d exp=1", it, n_eop); end
    end
  endtask

  task automatic test_reset_mid_packet();
    data_q.delete(); add_byte(8'h80);
    for (int i = 0; i < 5; i++) data_q.push_back(1'($urandom));
    exp_q = data_q;
    make_wire(1'b1);
    make_line(1'b0, 1'b0);
    clear_mon();
    play();
    n_checks++;
    if (bit_errs() != 0) begin n_fail++; $display("FAIL midrst_pre_bits got_len=%0d exp_len=%0d", got_q.size(), exp_q.size()); end
    rst = 1'b1;
    {bus.d_plus_sync, bus.d_minus_sync} = LJ;
    cyc();
    n_checks++;
    if (outs() !== 7'b0) begin n_fail++; $display("FAIL midrst_outputs got=%b exp=%b", outs(), 7'b0); end
    rst = 1'b0;
    idle(5);
    data_q.delete(); add_byte(8'h80); add_byte(8'($urandom));
    exp_q = data_q;
    run_packet(1'b1, 1'b0);
    n_checks++;
    if (bit_errs() != 0) begin n_fail++; $display("FAIL midrst_fresh_bits got_len=%0d exp_len=%0d errs=%0d", got_q.size(), exp_q.size(), bit_errs()); end
    n_checks++;
    if (n_bd != 2) begin n_fail++; $display("FAIL midrst_byte_done got=%0d exp=2", n_bd); end
  endtask

  task automatic test_sync_check();
    logic [7:0] bad;
    logic       exp_bad;
`ifdef USB_RX_SYNC_CHECK_EN
    exp_bad = 1'b1;
`else
    exp_bad = 1'b0;
`endif
    do bad = 8'($urandom) & 8'hFE; while (bad == 8'h80);
    data_q.delete(); add_byte(bad); add_byte(8'($urandom));
    exp_q = data_q;
    run_packet(1'b1, 1'b0);
    n_checks++;
    if (bd_sync !== exp_bad) begin n_fail++; $display("FAIL sync_bad byte=%h got=%b exp=%b", bad, bd_sync, exp_bad); end
    n_checks++;
    if (n_bd != 2 || bit_errs() != 0) begin n_fail++; $display("FAIL sync_bad_continue got_bd=%0d errs=%0d exp_bd=2 errs=0", n_bd, bit_errs()); end
    data_q.delete(); add_byte(8'h80); add_byte(8'($urandom));
    exp_q = data_q;
    run_packet(1'b1, 1'b0);
    n_checks++;
    if (bd_sync !== 1'b0) begin n_fail++; $display("FAIL sync_good got=%b exp=0", bd_sync); end
    n_checks++;
    if (bus.sync_err !== 1'b0) begin n_fail++; $display("FAIL sync_good_end got=%b exp=0", bus.sync_err); end
  endtask

  initial begin
    bus.d_plus_sync  = 1'b1;
    bus.d_minus_sync = 1'b0;
    clear_mon();
    test_reset();
    test_basic();
    test_stuffing();
    test_stuff_error();
    test_drift();
    test_partial_random();
    test_reset_mid_packet();
    test_sync_check();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
